// File: rtl/icache_fill_unit.sv
// Direct-mapped read-only instruction cache with two-word block fill over the
// controller's iREN/iaddr/iwait handshake, plus hit/miss performance counters.
module icache_fill_unit #(
    parameter int unsigned SETS = 8,
    parameter int unsigned TAGW = 26
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IW = $clog2(SETS);

    typedef enum logic [1:0] {
        IDLE,
        FETCH0,
        FETCH1
    } state_t;

    state_t state, next_state, out_state;

    logic [SETS-1:0] valid;
    logic [TAGW-1:0] tags  [SETS];
    logic [31:0]     data0 [SETS];
    logic [31:0]     data1 [SETS];

    logic [31:0] miss_addr;
    logic [31:0] word0;
    logic        flush_pend;

    logic [TAGW-1:0] req_tag;
    logic [IW-1:0]   req_idx;
    logic            req_wsel;
    logic [TAGW-1:0] miss_tag;
    logic [IW-1:0]   miss_idx;
    logic            lookup_hit;

    logic start_miss;
    logic take_word0;
    logic fill_done;

    logic unused_addr_bits;

    assign req_tag  = imemaddr[31 -: TAGW];
    assign req_idx  = imemaddr[3 +: IW];
    assign req_wsel = imemaddr[2];
    assign miss_tag = miss_addr[31 -: TAGW];
    assign miss_idx = miss_addr[3 +: IW];

    assign unused_addr_bits = ^imemaddr[1:0];

    // Outputs obey IDLE rules with every frame invalid while reset is held,
    // even before the registered state and valid bits have been cleared.
    assign out_state  = RST ? IDLE : state;
    assign lookup_hit = !RST && valid[req_idx] && (tags[req_idx] == req_tag);

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        start_miss = 1'b0;
        take_word0 = 1'b0;
        fill_done  = 1'b0;
        case (out_state)
            IDLE: begin
                ihit = imemREN && lookup_hit;
                if (ihit) begin
                    imemload = req_wsel ? data1[req_idx] : data0[req_idx];
                end
                if (imemREN && !lookup_hit) begin
                    start_miss = 1'b1;
                    next_state = FETCH0;
                end
            end
            FETCH0: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait) begin
                    take_word0 = 1'b1;
                    next_state = FETCH1;
                end
            end
            FETCH1: begin
                iREN  = 1'b1;
                iaddr = miss_addr | 32'h4;
                if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= next_state;
            if (ihit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_miss) begin
                miss_addr  <= {imemaddr[31:3], 3'b000};
                miss_count <= miss_count + 32'd1;
            end
            if (take_word0) begin
                word0 <= iload;
            end
            // A flush seen anywhere during the fill wipes every frame,
            // including the one being filled, on the completion edge.
            if (fill_done) begin
                flush_pend <= 1'b0;
                if (flush_pend || flush) begin
                    valid <= '0;
                end else begin
                    valid[miss_idx] <= 1'b1;
                end
            end else if (flush) begin
                if (state == IDLE) begin
                    valid <= '0;
                end else begin
                    flush_pend <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[miss_idx]  <= miss_tag;
            data0[miss_idx] <= word0;
            data1[miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_fill_unit.sv
// Self-checking bench for icache_fill_unit: directed scenarios followed by
// randomized reads/flushes compared against a per-set behavioural cache model.
module tb_icache_fill_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: per-set valid/tag/two data words, plus counters
    bit          mv [8];
    logic [25:0] mt [8];
    logic [31:0] md [8][2];
    logic [31:0] m_hits;
    logic [31:0] m_miss;

    icache_fill_unit #(.SETS(8), .TAGW(26)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .flush     (flush),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    endtask

    task automatic chk_counts();
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_miss);
    endtask

    // One fetch request; on a miss the whole fill is served with s0/s1 stall
    // cycles, an optional flush pulse in phase fph, and imemaddr moved to alt.
    task automatic read(input logic [31:0] addr, input int s0, input int s1,
                        input int fph, input logic [31:0] alt);
        logic [2:0]  ix;
        logic [25:0] tg;
        logic [31:0] base;
        bit          hit;
        bit          flushed;
        ix      = addr[5:3];
        tg      = addr[31:6];
        base    = {addr[31:3], 3'b000};
        flushed = 1'b0;
        imemREN  = 1'b1;
        imemaddr = addr;
        flush    = 1'b0;
        iwait    = 1'($urandom);
        iload    = $urandom;
        #1;
        hit = mv[ix] && (mt[ix] == tg);
        chk("ihit", ihit, hit);
        chk("iREN_idle", iREN, 0);
        if (hit) begin
            chk("imemload_hit", imemload, md[ix][addr[2]]);
            m_hits++;
            cyc();
        end else begin
            chk("imemload_miss", imemload, 0);
            m_miss++;
            cyc();
            for (int ph = 0; ph < 2; ph++) begin
                int s;
                s = (ph == 0) ? s0 : s1;
                for (int k = 0; k <= s; k++) begin
                    imemaddr = alt;
                    imemREN  = 1'($urandom);
                    iwait    = (k < s);
                    iload    = (k < s) ? $urandom : mem(base | 32'(ph * 4));
                    flush    = (fph == ph) && (k == 0);
                    if (flush) flushed = 1'b1;
                    #1;
                    chk("iREN_fill", iREN, 1);
                    chk("iaddr", iaddr, base | 32'(ph * 4));
                    chk("ihit_fill", ihit, 0);
                    cyc();
                end
            end
            flush = 1'b0;
            mt[ix]    = tg;
            md[ix][0] = mem(base);
            md[ix][1] = mem(base | 32'h4);
            if (flushed) model_clear();
            else mv[ix] = 1'b1;
        end
        imemREN = 1'b0;
        chk_counts();
    endtask

    task automatic idle_flush(input logic [31:0] addr);
        bit hit;
        hit      = mv[addr[5:3]] && (mt[addr[5:3]] == addr[31:6]);
        imemaddr = addr;
        imemREN  = hit;
        flush    = 1'b1;
        #1;
        chk("ihit_flush", ihit, hit);
        if (hit) begin
            chk("imemload_flush", imemload, md[addr[5:3]][addr[2]]);
            m_hits++;
        end
        cyc();
        flush   = 1'b0;
        imemREN = 1'b0;
        model_clear();
        chk_counts();
    endtask

    function automatic logic [31:0] pool_addr();
        return ($urandom_range(0, 3) * 32'h200) | ($urandom_range(0, 7) << 3)
             | ($urandom_range(0, 1) << 2);
    endfunction

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; flush = 1'b0;
        iwait = 1'b1; iload = '0;
        model_clear();
        m_hits = '0; m_miss = '0;
        cyc(); cyc();
        chk("rst_ihit", ihit, 0);
        chk("rst_iREN", iREN, 0);
        RST = 1'b0;
        #1;
        chk("rst_iaddr", iaddr, 0);
        chk_counts();

        // cold miss, 3 stall cycles per word, then retry hit
        read(32'h40, 3, 3, -1, 32'h40);
        read(32'h40, 0, 0, -1, 32'h40);
        chk("t1_miss", miss_count, 1);
        chk("t1_hit", hit_count, 1);
        read(32'h44, 0, 0, -1, 32'h44);
        chk("t2_hit", hit_count, 2);

        // conflict on set 0
        read(32'h240, 1, 0, -1, 32'h240);
        read(32'h40, 0, 2, -1, 32'h40);
        chk("t3_miss", miss_count, 3);

        // flush during FETCH1 of 0x80: frame stays invalid
        read(32'h80, 1, 2, 1, 32'h80);
        read(32'h80, 0, 0, -1, 32'h80);
        chk("t4_miss", miss_count, 5);
        read(32'h80, 0, 0, -1, 32'h80);

        // fetch address moves mid-fill
        read(32'h100, 2, 1, -1, 32'h200);
        read(32'h200, 0, 0, -1, 32'h200);

        // reset during FETCH0
        imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b1;
        cyc();
        #1;
        chk("t6_fetch0", iREN, 1);
        RST = 1'b1;
        #1;
        chk("t6_rst_iREN", iREN, 0);
        cyc();
        RST = 1'b0; imemREN = 1'b0;
        #1;
        chk("t6_after_iREN", iREN, 0);
        model_clear();
        m_hits = '0; m_miss = '0;
        chk_counts();
        read(32'h300, 1, 1, -1, 32'h300);
        chk("t6_miss", miss_count, 1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle_flush(pool_addr());
            end else begin
                int fph;
                fph = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1;
                read(pool_addr(), $urandom_range(0, 3), $urandom_range(0, 3), fph, pool_addr());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
